// File: rtl/idma_realign_buffer.sv
// Byte-lane realignment buffer: inbound bytes are rotated into per-lane FIFOs,
// and the FIFO heads are rotated back out under an independent shift amount.
module idma_realign_buffer #(
  parameter int unsigned StrbWidth       = 8,
  parameter int unsigned BufferDepth     = 3,
  parameter bit          MaskInvalidData = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [$clog2(StrbWidth)-1:0] in_shift_i,
  input  logic [8*StrbWidth-1:0]       in_data_i,
  input  logic [StrbWidth-1:0]         in_valid_i,
  output logic [StrbWidth-1:0]         in_ready_o,
  input  logic [$clog2(StrbWidth)-1:0] out_shift_i,
  output logic [8*StrbWidth-1:0]       out_data_o,
  output logic [StrbWidth-1:0]         out_valid_o,
  input  logic [StrbWidth-1:0]         out_ready_i,
  output logic                         busy_o,
  output logic [StrbWidth-1:0]         lane_full_o
);

  localparam int unsigned ShiftW = $clog2(StrbWidth);
  localparam int unsigned PtrW   = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;
  localparam int unsigned CntW   = $clog2(BufferDepth + 1);

  typedef logic [ShiftW-1:0] lane_idx_t;

  logic [7:0]      mem_q  [StrbWidth][BufferDepth];
  logic [PtrW-1:0] wptr_q [StrbWidth];
  logic [PtrW-1:0] wptr_d [StrbWidth];
  logic [PtrW-1:0] rptr_q [StrbWidth];
  logic [PtrW-1:0] rptr_d [StrbWidth];
  logic [CntW-1:0] cnt_q  [StrbWidth];
  logic [CntW-1:0] cnt_d  [StrbWidth];
  logic [7:0]      lane_data [StrbWidth];
  logic [StrbWidth-1:0] full, empty, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufferDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Per-lane occupancy flags derived from the count registers
  always_comb begin
    full  = '0;
    empty = '0;
    for (int unsigned k = 0; k < StrbWidth; k++) begin
      full[k]  = (cnt_q[k] == CntW'(BufferDepth));
      empty[k] = (cnt_q[k] == '0);
    end
  end

  // Inbound rotation: lane k takes input byte k+in_shift (index wraps mod StrbWidth)
  always_comb begin
    lane_idx_t src;
    src        = '0;
    push       = '0;
    in_ready_o = '0;
    for (int unsigned k = 0; k < StrbWidth; k++) begin
      src             = lane_idx_t'(k) + in_shift_i;
      lane_data[k]    = in_data_i[8*src +: 8];
      push[k]         = in_valid_i[src] & ~full[k] & ~flush_i;
      in_ready_o[src] = ~full[k] & ~flush_i;
    end
  end

  // Outbound rotation: output byte j shows the head of lane j+out_shift
  always_comb begin
    lane_idx_t lane;
    lane        = '0;
    pop         = '0;
    out_valid_o = '0;
    out_data_o  = '0;
    for (int unsigned j = 0; j < StrbWidth; j++) begin
      lane           = lane_idx_t'(j) + out_shift_i;
      out_valid_o[j] = ~empty[lane];
      pop[lane]      = ~empty[lane] & out_ready_i[j] & ~flush_i;
      if (~empty[lane] || !MaskInvalidData) begin
        out_data_o[8*j +: 8] = mem_q[lane][rptr_q[lane]];
      end
    end
  end

  // Pointer and count next-state; flush overrides any push/pop in the same cycle
  always_comb begin
    for (int unsigned k = 0; k < StrbWidth; k++) begin
      wptr_d[k] = wptr_q[k];
      rptr_d[k] = rptr_q[k];
      cnt_d[k]  = cnt_q[k];
      if (flush_i) begin
        wptr_d[k] = '0;
        rptr_d[k] = '0;
        cnt_d[k]  = '0;
      end else begin
        if (push[k]) wptr_d[k] = ptr_inc(wptr_q[k]);
        if (pop[k])  rptr_d[k] = ptr_inc(rptr_q[k]);
        case ({push[k], pop[k]})
          2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
          2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
          default: cnt_d[k] = cnt_q[k];
        endcase
      end
    end
  end

  // Pointer and count state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < StrbWidth; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < StrbWidth; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  // FIFO storage; contents are only meaningful behind a valid count, so no reset
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < StrbWidth; k++) begin
      if (push[k]) mem_q[k][wptr_q[k]] <= lane_data[k];
    end
  end

  assign busy_o      = ~&empty;
  assign lane_full_o = full;

endmodule

// File: tb/tb_idma_realign_buffer.sv
// Self-checking bench for idma_realign_buffer (4 lanes, depth 3, masking on).
module tb_idma_realign_buffer;

  localparam int S = 4;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  ish, osh;
  logic [31:0] idata, odata;
  logic [3:0]  ivld, irdy, ovld, ordy, lfull;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  // Expected bytes per buffer lane, oldest first
  logic [7:0] sb_q [S][$];

  typedef struct {
    logic [1:0]  ish;
    logic [31:0] dat;
    logic [3:0]  vld;
    logic [1:0]  osh;
    logic [3:0]  rdy;
    logic [31:0] exp_dat;
    logic [3:0]  exp_vld;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  idma_realign_buffer #(
    .StrbWidth      (S),
    .BufferDepth    (D),
    .MaskInvalidData(1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .in_shift_i (ish),
    .in_data_i  (idata),
    .in_valid_i (ivld),
    .in_ready_o (irdy),
    .out_shift_i(osh),
    .out_data_o (odata),
    .out_valid_o(ovld),
    .out_ready_i(ordy),
    .busy_o     (busy),
    .lane_full_o(lfull)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare all outputs of the current cycle against the lane model
  task automatic check_outputs();
    logic [3:0] e_rdy, e_vld, e_full;
    logic       e_busy;
    int         l;
    e_rdy = '0; e_vld = '0; e_full = '0; e_busy = 1'b0;
    for (int j = 0; j < S; j++) begin
      l = (j - int'(ish) + S) % S;
      e_rdy[j] = !flush && (sb_q[l].size() < D);
    end
    for (int j = 0; j < S; j++) begin
      l = (j + int'(osh)) % S;
      e_vld[j] = (sb_q[l].size() != 0);
      if (e_vld[j]) chk($sformatf("head_byte%0d", j), 32'(odata[8*j +: 8]), 32'(sb_q[l][0]));
      else          chk($sformatf("mask_byte%0d", j), 32'(odata[8*j +: 8]), 32'h0);
    end
    for (int k = 0; k < S; k++) begin
      e_full[k] = (sb_q[k].size() == D);
      if (sb_q[k].size() != 0) e_busy = 1'b1;
    end
    chk("in_ready",  32'(irdy),  32'(e_rdy));
    chk("out_valid", 32'(ovld),  32'(e_vld));
    chk("lane_full", 32'(lfull), 32'(e_full));
    chk("busy",      32'(busy),  32'(e_busy));
  endtask

  // Advance the lane model by the clock edge that closes the current cycle
  task automatic update_model();
    bit acc [S];
    int src, l;
    for (int k = 0; k < S; k++) begin
      src    = (k + int'(ish)) % S;
      acc[k] = ivld[src] && (sb_q[k].size() < D);
    end
    if (flush) begin
      for (int k = 0; k < S; k++) sb_q[k].delete();
      return;
    end
    for (int j = 0; j < S; j++) begin
      l = (j + int'(osh)) % S;
      if (sb_q[l].size() != 0 && ordy[j]) void'(sb_q[l].pop_front());
    end
    for (int k = 0; k < S; k++) begin
      src = (k + int'(ish)) % S;
      if (acc[k]) sb_q[k].push_back(idata[8*src +: 8]);
    end
  endtask

  // One cycle: drive at the falling edge, check shortly after, then model the rising edge
  task automatic step(input logic [1:0] a_ish, input logic [31:0] a_dat, input logic [3:0] a_vld,
                      input logic [1:0] a_osh, input logic [3:0] a_rdy, input logic a_fl);
    @(negedge clk);
    ish = a_ish; idata = a_dat; ivld = a_vld; osh = a_osh; ordy = a_rdy; flush = a_fl;
    #1;
    check_outputs();
    update_model();
  endtask

  initial begin
    tbl[0] = '{ish: 2'd1, dat: 32'h44332211, vld: 4'hF, osh: 2'd0, rdy: 4'hF, exp_dat: 32'h11443322, exp_vld: 4'hF};
    tbl[1] = '{ish: 2'd0, dat: 32'hDDCCBBAA, vld: 4'h5, osh: 2'd0, rdy: 4'hF, exp_dat: 32'h00CC00AA, exp_vld: 4'h5};
    tbl[2] = '{ish: 2'd2, dat: 32'h87654321, vld: 4'hF, osh: 2'd1, rdy: 4'hF, exp_dat: 32'h65432187, exp_vld: 4'hF};
    tbl[3] = '{ish: 2'd3, dat: 32'hA1B2C3D4, vld: 4'h3, osh: 2'd2, rdy: 4'h1, exp_dat: 32'hD40000C3, exp_vld: 4'h9};
    tbl[4] = '{ish: 2'd0, dat: 32'h01020304, vld: 4'h8, osh: 2'd3, rdy: 4'hF, exp_dat: 32'h00000001, exp_vld: 4'h1};

    rst_n = 1'b1; flush = 1'b0; ish = '0; osh = '0; idata = '0; ivld = '0; ordy = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(ovld), 32'h0);
    chk("rst_out_data",  odata,     32'h0);
    chk("rst_busy",      32'(busy), 32'h0);
    chk("rst_lane_full", 32'(lfull), 32'h0);
    chk("rst_in_ready",  32'(irdy), 32'hF);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Table vectors, each from an empty buffer
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].ish, tbl[i].dat, tbl[i].vld, 2'd0, 4'h0, 1'b0);
      step(tbl[i].ish, 32'h0, 4'h0, tbl[i].osh, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_data", i),  odata,        tbl[i].exp_dat);
      chk($sformatf("tbl%0d_valid", i), 32'(ovld),    32'(tbl[i].exp_vld));
      step(2'd0, 32'h0, 4'h0, 2'd0, 4'hF, 1'b0);
      step(2'd0, 32'h0, 4'h0, 2'd0, 4'h0, 1'b0);
      chk($sformatf("tbl%0d_idle", i), 32'(busy), 32'h0);
    end

    // Fill lane 0, stall, pop while full, then drain in order
    step(2'd0, 32'h01, 4'h1, 2'd0, 4'h0, 1'b0);
    step(2'd0, 32'h02, 4'h1, 2'd0, 4'h0, 1'b0);
    step(2'd0, 32'h03, 4'h1, 2'd0, 4'h0, 1'b0);
    step(2'd0, 32'h04, 4'h1, 2'd0, 4'h0, 1'b0);
    chk("full_flag", 32'(lfull), 32'h1);
    chk("full_rdy0", 32'(irdy[0]), 32'h0);
    step(2'd0, 32'h05, 4'h1, 2'd0, 4'h1, 1'b0);
    chk("full_pop_rdy0", 32'(irdy[0]), 32'h0);
    chk("full_pop_head", 32'(odata[7:0]), 32'h01);
    step(2'd0, 32'h0, 4'h0, 2'd0, 4'h0, 1'b0);
    chk("after_pop_rdy0", 32'(irdy[0]), 32'h1);
    chk("after_pop_full", 32'(lfull), 32'h0);
    step(2'd0, 32'h0, 4'h0, 2'd0, 4'h1, 1'b0);
    chk("drain_2nd", 32'(odata[7:0]), 32'h02);
    step(2'd0, 32'h0, 4'h0, 2'd0, 4'h1, 1'b0);
    chk("drain_3rd", 32'(odata[7:0]), 32'h03);
    step(2'd0, 32'h0, 4'h0, 2'd0, 4'h0, 1'b0);
    chk("drain_idle", 32'(busy), 32'h0);

    // Flush with two entries in every lane
    step(2'd0, 32'hA0B0C0D0, 4'hF, 2'd0, 4'h0, 1'b0);
    step(2'd0, 32'hA1B1C1D1, 4'hF, 2'd0, 4'h0, 1'b0);
    step(2'd0, 32'hEEEEEEEE, 4'hF, 2'd0, 4'hF, 1'b1);
    chk("flush_rdy", 32'(irdy), 32'h0);
    chk("flush_vld", 32'(ovld), 32'hF);
    step(2'd0, 32'h0, 4'h0, 2'd0, 4'hF, 1'b0);
    chk("post_flush_vld",  32'(ovld), 32'h0);
    chk("post_flush_busy", 32'(busy), 32'h0);

    // Asynchronous reset while data is buffered
    step(2'd0, 32'h11223344, 4'hF, 2'd0, 4'h0, 1'b0);
    step(2'd0, 32'h0, 4'h0, 2'd0, 4'h0, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ovld), 32'h0);
    chk("mid_rst_out_data",  odata,     32'h0);
    chk("mid_rst_busy",      32'(busy), 32'h0);
    chk("mid_rst_lane_full", 32'(lfull), 32'h0);
    chk("mid_rst_in_ready",  32'(irdy), 32'hF);
    for (int k = 0; k < S; k++) sb_q[k].delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(2'd0, 32'h00000055, 4'h1, 2'd0, 4'h0, 1'b0);
    chk("rel_first_vld", 32'(ovld), 32'h0);
    step(2'd0, 32'h0, 4'h0, 2'd0, 4'h1, 1'b0);
    chk("rel_next_vld",  32'(ovld), 32'h1);
    chk("rel_next_data", odata,     32'h55);

    // Random traffic with shifting lane maps and occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(3, 0)), $urandom, 4'($urandom_range(15, 0)),
           2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)), ($urandom_range(15, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
